// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester arbiter and sequencer for the 16-bit address /
// 8-bit data memory bus. Requester 0 is the CPU, requester 1 the DMA/debug
// master. One transaction at a time runs through IDLE -> ACCESS -> DONE.
// A watchdog aborts an access after TIMEOUT not-ready cycles.
// Optional feature: define BUS_ARB_RR_EN for round-robin tie-breaking;
// without it the CPU has fixed priority on simultaneous requests.
module bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_read,
    input  logic        dma_write,
    output logic [7:0]  dma_rdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        wr_q;        // latched direction: 1 = write
    logic        id_q;        // latched owner: 0 = CPU, 1 = DMA
    logic [7:0]  cnt_q;       // not-ready cycles seen in ACCESS
    logic        err_q;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  dma_rdata_q;

    logic        cpu_req, dma_req, any_req;
    logic        grant_dma;
    logic        timed_out;
    logic        finish;
    logic [7:0]  cap_data;

    assign cpu_req = cpu_read | cpu_write;
    assign dma_req = dma_read | dma_write;
    assign any_req = cpu_req | dma_req;

`ifdef BUS_ARB_RR_EN
    logic last_dma_q;         // 1 = DMA was granted last

    // On a tie the requester not granted last wins.
    assign grant_dma = dma_req & (~cpu_req | ~last_dma_q);

    // Round-robin pointer: follows every grant; resets to "CPU last".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dma_q <= 1'b0;
        end else if (state_q == IDLE && any_req) begin
            last_dma_q <= grant_dma;
        end
    end
`else
    // Fixed priority: the DMA only wins when the CPU is not asking.
    assign grant_dma = dma_req & ~cpu_req;
`endif

    // The counter is compared before it increments, so an access that never
    // sees mem_ready spends TIMEOUT+1 cycles in ACCESS.
    assign timed_out = (cnt_q == TIMEOUT_CNT);
    assign finish    = (state_q == ACCESS) && (mem_ready || timed_out);
    assign cap_data  = mem_ready ? (wr_q ? 8'h00 : mem_rdata) : 8'hFF;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches
        // on paths that do not change state.
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (mem_ready || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and watchdog: inputs are sampled only in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        id_q    <= grant_dma;
                        addr_q  <= grant_dma ? dma_addr  : cpu_addr;
                        wdata_q <= grant_dma ? dma_wdata : cpu_wdata;
                        // Read and write together is treated as a write.
                        wr_q    <= grant_dma ? dma_write : cpu_write;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        err_q <= 1'b0;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-requester read data: updated only on that requester's completion
    // and held afterwards; ack is what qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (finish) begin
            if (id_q) dma_rdata_q <= cap_data;
            else      cpu_rdata_q <= cap_data;
        end
    end

    // Strobes are decoded from state so an asynchronous reset drops them
    // immediately. Address and data simply present the latched request.
    assign mem_read  = (state_q == ACCESS) && !wr_q;
    assign mem_write = (state_q == ACCESS) &&  wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_ack   = (state_q == DONE) && !id_q;
    assign dma_ack   = (state_q == DONE) &&  id_q;
    assign cpu_err   = cpu_ack && err_q;
    assign dma_err   = dma_ack && err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule
